seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle ALU for the next-generation core datapath; successor to the fixed 8-bit combinational ALU.
//  Adds multi-cycle shift-by-N and shift-add multiply, a start/busy/done handshake and registered flags.
//  Sits between the register file read ports and the writeback mux. The control FSM stalls on busy and writes back on done.
// PARAMETERS
//  W       8   operand/result width in bits (>=4)
//  MUL_EN  1   1: MUL implemented; 0: MUL is illegal (single-cycle, sets ill)
//  (local) SHW = $clog2(W); shift amount is b[SHW-1:0]
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      asynchronous, active-low reset (0 = reset)
//  start   in   1      request; sampled only when busy=0
//  op      in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR(logical), 111 MUL
//  a       in   W      operand A; latched on accepted start
//  b       in   W      operand B / shift amount; latched on accepted start
//  busy    out  1      operation in progress
//  done    out  1      one-cycle pulse: result and flags are valid
//  result  out  W      registered result; held until next done
//  zero    out  1      result == 0
//  carry   out  1      ADD carry-out; SUB borrow (a<b unsigned); shifts: last bit shifted out; MUL: any of high W product bits != 0
//  ovf     out  1      signed overflow for ADD/SUB; 0 for all other ops
//  ill     out  1      op=MUL with MUL_EN=0; result=0
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; busy, done, result, zero, carry, ovf, ill all 0; internal regs cleared.
//  - States: IDLE -> EXEC on start&&!busy. EXEC -> IDLE on the finishing edge, which sets done=1.
//  - Accept edge E0: latch op/a/b; load cnt: 0 for ADD..XOR and illegal MUL; b[SHW-1:0] for SHL/SHR; W for MUL. busy=1 from E0.
//  - EXEC, cnt!=0: one step per edge. Shift moves 1 bit and records the bit out; MUL does one shift-add step (2W-bit accumulator). cnt--.
//  - EXEC, cnt==0: the finishing edge. It registers result/flags, sets done=1 and busy=0, and returns to IDLE.
//  - Latency: done is high in the cycle after edge E0+N.
//    N=1 for ADD..XOR and illegal MUL; N=1+shamt for shifts (shamt=0 -> result=a, carry=0); N=1+W for MUL.
//  - done lasts exactly one cycle. result, flags and ill hold until the next finishing edge.
//  - start while busy=1 is ignored: no effect on the operands or on cnt.
//  - start in the same cycle as done=1 is accepted (back-to-back). Busy then rises at that edge.
//  - Result arithmetic is modulo 2^W.
//  - ovf: ADD = a[W-1]==b[W-1] && r[W-1]!=a[W-1]; SUB = a[W-1]!=b[W-1] && r[W-1]!=a[W-1].
//  - Reset asserted mid-operation aborts immediately to the reset values. No done is produced for the aborted op.
//  - Inputs a/b/op may change freely after the accept edge; only the latched copies are used.
// TESTING (W=8 unless noted)
//  1. ADD a=200,b=100 -> done 1 cycle after accept; result=44, carry=1, ovf=0. ADD 100+100 -> 200, ovf=1, carry=0.
//  2. SUB 5-5 -> result=0, zero=1, carry=0. SUB 3-5 -> 254, carry=1, ovf=0. SUB 0x80-1 -> 0x7F, ovf=1.
//  3. SHL a=0x81,b=1 -> 0x02, carry=1, N=2. SHL a=0x81,b=3 -> 0x08, carry=0, N=4. SHR a=0x81,b=0 -> 0x81, carry=0, N=1.
//  4. MUL 15*17 -> 255, carry=0, done after 9 edges. MUL 16*16 -> 0, zero=1, carry=1.
//  5. start pulsed mid-MUL with new a/b -> ignored; original product returned.
//     start during done -> accepted, busy=1 next cycle.
//  6. reset=0 mid-MUL -> all outputs 0 at once, no done; next ADD 1+1 -> 2.
//     MUL_EN=0 build: MUL 3*3 -> ill=1, result=0, N=1.

Source files
------------

// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response bundle between issue logic and the sequential ALU
interface seq_alu_if #(
  parameter int W = 8
);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         ovf;
  logic         ill;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry, ovf, ill
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry, ovf, ill
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/arith, bit-serial shifts, shift-add multiply
module seq_alu #(
  parameter int W      = 8,
  parameter int MUL_EN = 1
) (
  input  logic      clk,
  input  logic      reset,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sh;
  logic           sb;
  logic [2*W-1:0] acc;

  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   result_q;
  logic           zero_q;
  logic           carry_q;
  logic           ovf_q;
  logic           ill_q;

  logic [CW-1:0]  load_cnt;
  logic [W:0]     mul_sum;
  logic [W:0]     add_full;
  logic [W-1:0]   sub_r;
  logic [W-1:0]   fin_res;
  logic           fin_carry;
  logic           fin_ovf;
  logic           fin_ill;

  always_comb begin
    load_cnt = '0;
    if (bus.op == OP_SHL || bus.op == OP_SHR)
      load_cnt = CW'(bus.b[SHW-1:0]);
    else if (bus.op == OP_MUL && MUL_EN != 0)
      load_cnt = CW'(W);
  end

  // Multiplier lives in acc's low half and drains out to the right as the product fills in.
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : '0);
  end

  always_comb begin
    add_full  = {1'b0, a_q} + {1'b0, b_q};
    sub_r     = a_q - b_q;
    fin_res   = '0;
    fin_carry = 1'b0;
    fin_ovf   = 1'b0;
    fin_ill   = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_res   = add_full[W-1:0];
        fin_carry = add_full[W];
        fin_ovf   = (a_q[W-1] == b_q[W-1]) && (add_full[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        fin_res   = sub_r;
        fin_carry = (a_q < b_q);
        fin_ovf   = (a_q[W-1] != b_q[W-1]) && (sub_r[W-1] != a_q[W-1]);
      end
      OP_AND: fin_res = a_q & b_q;
      OP_OR:  fin_res = a_q | b_q;
      OP_XOR: fin_res = a_q ^ b_q;
      OP_SHL, OP_SHR: begin
        fin_res   = sh;
        fin_carry = sb;
      end
      default: begin
        if (MUL_EN != 0) begin
          fin_res   = acc[W-1:0];
          fin_carry = |acc[2*W-1:W];
        end else begin
          fin_ill   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      sh       <= '0;
      sb       <= 1'b0;
      acc      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            cnt    <= load_cnt;
            sh     <= bus.a;
            sb     <= 1'b0;
            acc    <= {{W{1'b0}}, bus.b};
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            case (op_q)
              OP_SHL: begin
                sb <= sh[W-1];
                sh <= {sh[W-2:0], 1'b0};
              end
              OP_SHR: begin
                sb <= sh[0];
                sh <= {1'b0, sh[W-1:1]};
              end
              default: acc <= {mul_sum, acc[W-1:1]};
            endcase
            cnt <= cnt - 1'b1;
          end else begin
            result_q <= fin_res;
            zero_q   <= (fin_res == '0);
            carry_q  <= fin_carry;
            ovf_q    <= fin_ovf;
            ill_q    <= fin_ill;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;
  assign bus.ill    = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed bench for seq_alu, MUL-enabled and MUL-disabled builds side by side
module tb_seq_alu;
  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  int         tests;
  int         fails;

  seq_alu_if #(.W(8)) if_m ();
  seq_alu_if #(.W(8)) if_n ();

  assign if_m.start = start;
  assign if_m.op    = op;
  assign if_m.a     = a;
  assign if_m.b     = b;
  assign if_n.start = start;
  assign if_n.op    = op;
  assign if_n.a     = a;
  assign if_n.b     = b;

  seq_alu #(.W(8), .MUL_EN(1)) dut   (.clk(clk), .reset(reset), .bus(if_m.slave));
  seq_alu #(.W(8), .MUL_EN(0)) dut_n (.clk(clk), .reset(reset), .bus(if_n.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic dn(input bit sel);
    return sel ? if_n.done : if_m.done;
  endfunction

  // Called #1 after a rising edge; returns edges from accept to the sampled done.
  task automatic run_op(input bit sel, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int n);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; op = 3'b010;
    chk("busy_after_accept", sel ? if_n.busy : if_m.busy, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!dn(sel) && n < 40);
    if (n >= 40) chk("done_timeout", 0, 1);
  endtask

  task automatic expect_res(input string tag, input bit sel, input int n, input int exp_n,
                            input logic [7:0] r, input logic c, input logic v, input logic il);
    if (sel) begin
      chk({tag, "_res"},  if_n.result, r);
      chk({tag, "_ill"},  if_n.ill, il);
      chk({tag, "_zero"}, if_n.zero, (r == 8'h00));
    end else begin
      chk({tag, "_res"},  if_m.result, r);
      chk({tag, "_c"},    if_m.carry, c);
      chk({tag, "_v"},    if_m.ovf, v);
      chk({tag, "_ill"},  if_m.ill, il);
      chk({tag, "_zero"}, if_m.zero, (r == 8'h00));
      chk({tag, "_busy"}, if_m.busy, 0);
    end
    chk({tag, "_lat"}, n, exp_n);
  endtask

  initial begin
    int n;
    int dcnt;
    tests = 0; fails = 0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", if_m.busy, 0);
    chk("rst_done", if_m.done, 0);
    chk("rst_result", if_m.result, 0);
    chk("rst_flags", {if_m.zero, if_m.carry, if_m.ovf, if_m.ill}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(0, 3'b000, 8'd200, 8'd100, n); expect_res("add1", 0, n, 1, 8'd44, 1, 0, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", if_m.done, 0);
    chk("result_held", if_m.result, 8'd44);
    run_op(0, 3'b000, 8'd100, 8'd100, n); expect_res("add2", 0, n, 1, 8'd200, 0, 1, 0);
    run_op(0, 3'b001, 8'd5, 8'd5, n);     expect_res("sub1", 0, n, 1, 8'd0, 0, 0, 0);
    run_op(0, 3'b001, 8'd3, 8'd5, n);     expect_res("sub2", 0, n, 1, 8'd254, 1, 0, 0);
    run_op(0, 3'b001, 8'h80, 8'h01, n);   expect_res("sub3", 0, n, 1, 8'h7F, 0, 1, 0);
    run_op(0, 3'b010, 8'hF0, 8'h3C, n);   expect_res("and", 0, n, 1, 8'h30, 0, 0, 0);
    run_op(0, 3'b011, 8'hF0, 8'h3C, n);   expect_res("or", 0, n, 1, 8'hFC, 0, 0, 0);
    run_op(0, 3'b100, 8'hF0, 8'h3C, n);   expect_res("xor", 0, n, 1, 8'hCC, 0, 0, 0);
    run_op(0, 3'b101, 8'h81, 8'd1, n);    expect_res("shl1", 0, n, 2, 8'h02, 1, 0, 0);
    run_op(0, 3'b101, 8'h81, 8'd3, n);    expect_res("shl3", 0, n, 4, 8'h08, 0, 0, 0);
    run_op(0, 3'b110, 8'h81, 8'd0, n);    expect_res("shr0", 0, n, 1, 8'h81, 0, 0, 0);
    run_op(0, 3'b110, 8'h81, 8'd1, n);    expect_res("shr1", 0, n, 2, 8'h40, 1, 0, 0);
    run_op(0, 3'b110, 8'hF0, 8'd7, n);    expect_res("shr7", 0, n, 8, 8'h01, 1, 0, 0);
    run_op(0, 3'b111, 8'd15, 8'd17, n);   expect_res("mul1", 0, n, 9, 8'd255, 0, 0, 0);
    run_op(0, 3'b111, 8'd16, 8'd16, n);   expect_res("mul2", 0, n, 9, 8'd0, 1, 0, 0);
    run_op(0, 3'b111, 8'd255, 8'd255, n); expect_res("mul3", 0, n, 9, 8'd1, 1, 0, 0);

    // start pulsed mid-MUL with different operands must be ignored
    start = 1'b1; op = 3'b111; a = 8'd15; b = 8'd17;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      if (n == 3) begin start = 1'b1; op = 3'b000; a = 8'd3; b = 8'd3; end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (!if_m.done && n < 40);
    if (n >= 40) chk("done_timeout", 0, 1);
    expect_res("mul_ign", 0, n, 9, 8'd255, 0, 0, 0);

    // back-to-back: start presented while done is high
    start = 1'b1; op = 3'b000; a = 8'd1; b = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", if_m.busy, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!if_m.done && n < 40);
    expect_res("b2b", 0, n, 1, 8'd3, 0, 0, 0);

    // reset in the middle of a multiply
    start = 1'b1; op = 3'b111; a = 8'd15; b = 8'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", if_m.busy, 0);
    chk("abort_result", if_m.result, 0);
    chk("abort_flags", {if_m.done, if_m.zero, if_m.carry, if_m.ovf, if_m.ill}, 0);
    @(negedge clk) reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if_m.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(0, 3'b000, 8'd1, 8'd1, n); expect_res("post_abort", 0, n, 1, 8'd2, 0, 0, 0);

    // MUL_EN=0 build
    run_op(1, 3'b111, 8'd3, 8'd3, n);  expect_res("ill_mul", 1, n, 1, 8'd0, 0, 0, 1);
    run_op(1, 3'b000, 8'd7, 8'd8, n);  expect_res("ill_clr", 1, n, 1, 8'd15, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
